// File: rtl/sys_arr_seq.sv
// Operand sequencer for a ROWS x COLS output-stationary systolic array.
// Takes one K-slice per handshake (A column + B row). Each lane is skewed into
// the array edge, the K slices are counted, and the wavefront and PE pipeline
// are allowed to drain before comp_done is raised.
module sys_arr_seq #(
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 2,
  parameter int unsigned DW     = 32,
  parameter int unsigned KMAX   = 16,
  parameter int unsigned PE_LAT = 4,
  localparam int unsigned KW    = $clog2(KMAX + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  input  logic [ROWS*DW-1:0] a_vec,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [COLS*DW-1:0] b_vec,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic               pe_err,
  output logic [ROWS*DW-1:0] row_data,
  output logic [ROWS-1:0]    row_en,
  output logic [COLS*DW-1:0] col_data,
  output logic [COLS-1:0]    col_en,
  output logic               pe_clear,
  output logic               busy,
  output logic               comp_done,
  output logic               error
);

  // Cycles after the last transfer before every PE holds its final result:
  // the far corner sees the last slice ROWS+COLS-1 cycles later, plus MAC latency.
  localparam int unsigned FlushLen  = ROWS + COLS - 2 + PE_LAT;
  localparam int unsigned FW        = (FlushLen > 2) ? $clog2(FlushLen) : 1;
  localparam logic [FW-1:0] FlushLoad = (FlushLen > 0) ? FW'(FlushLen - 1) : '0;
  localparam logic [KW-1:0] KMaxW   = KW'(KMAX);

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StFlush, StDone} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          error_q, error_d;

  logic xfer;
  logic last_xfer;
  logic k_ok;

  assign xfer      = (state_q == StFeed) & a_valid & b_valid;
  assign last_xfer = xfer & ((cnt_q + KW'(1)) == k_q);
  assign k_ok      = (k_len != '0) && (k_len <= KMaxW);

  assign a_ready   = (state_q == StFeed) & b_valid;
  assign b_ready   = (state_q == StFeed) & a_valid;
  assign pe_clear  = (state_q == StClear);
  assign busy      = (state_q == StClear) | (state_q == StFeed) | (state_q == StFlush);
  assign comp_done = (state_q == StDone);
  assign error     = error_q;

  // Control state registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      k_q     <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      error_q <= error_d;
    end
  end

  // Next-state: run sequencing, slice counting, flush countdown, error tracking.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    error_d = error_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (k_ok) begin
            k_d     = k_len;
            cnt_d   = '0;
            error_d = 1'b0;
            state_d = StClear;
          end else begin
            // Rejected start: flag it, keep the current state and comp_done.
            error_d = 1'b1;
          end
        end
      end
      StClear: state_d = StFeed;
      StFeed: begin
        if (xfer) begin
          cnt_d = cnt_q + KW'(1);
          if (last_xfer) begin
            flush_d = FlushLoad;
            state_d = (FlushLen == 0) ? StDone : StFlush;
          end
        end
      end
      StFlush: begin
        if (flush_q == '0) begin
          state_d = StDone;
        end else begin
          flush_d = flush_q - FW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (busy && pe_err) begin
      error_d = 1'b1;
    end
  end

  // A lanes: lane i passes through i+1 stages; stage 0 holds data on bubbles.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    logic [DW-1:0] dat_q [0:i];
    logic [i:0]    en_q;

    // Shift the lane's skew chain every cycle.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        en_q <= '0;
        for (int s = 0; s <= i; s++) begin
          dat_q[s] <= '0;
        end
      end else begin
        en_q[0] <= xfer;
        if (xfer) begin
          dat_q[0] <= a_vec[i*DW +: DW];
        end
        for (int s = 1; s <= i; s++) begin
          en_q[s]  <= en_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign row_data[i*DW +: DW] = dat_q[i];
    assign row_en[i]            = en_q[i];
  end

  // B lanes: lane j passes through j+1 stages; stage 0 holds data on bubbles.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic [DW-1:0] dat_q [0:j];
    logic [j:0]    en_q;

    // Shift the lane's skew chain every cycle.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        en_q <= '0;
        for (int s = 0; s <= j; s++) begin
          dat_q[s] <= '0;
        end
      end else begin
        en_q[0] <= xfer;
        if (xfer) begin
          dat_q[0] <= b_vec[j*DW +: DW];
        end
        for (int s = 1; s <= j; s++) begin
          en_q[s]  <= en_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign col_data[j*DW +: DW] = dat_q[j];
    assign col_en[j]            = en_q[j];
  end

endmodule

// File: tb/tb_sys_arr_seq.sv
// Bench for sys_arr_seq: a 2x2/PE_LAT=4 instance and a 4x3/PE_LAT=6 instance,
// checked every cycle against a timing-based reference model plus literal checks.
module tb_sys_arr_seq;

  localparam int NH = 4096;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             nRST;
  logic [1:0]       start, av, bv, perr;
  logic [1:0][4:0]  klen;
  logic [1:0][127:0] avec, bvec;

  wire [1:0]         o_ar, o_br, o_pc, o_bs, o_cd, o_er;
  wire [1:0][3:0]    o_re, o_ce;
  wire [1:0][127:0]  o_rd, o_cdt;

  assign o_re[0][3:2]    = 2'b0;
  assign o_ce[0][3:2]    = 2'b0;
  assign o_ce[1][3]      = 1'b0;
  assign o_rd[0][127:64] = '0;
  assign o_cdt[0][127:64] = '0;
  assign o_cdt[1][127:96] = '0;

  sys_arr_seq #(.ROWS(2), .COLS(2), .DW(32), .KMAX(16), .PE_LAT(4)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .start(start[0]), .k_len(klen[0]),
    .a_vec(avec[0][63:0]), .a_valid(av[0]), .a_ready(o_ar[0]),
    .b_vec(bvec[0][63:0]), .b_valid(bv[0]), .b_ready(o_br[0]),
    .pe_err(perr[0]), .row_data(o_rd[0][63:0]), .row_en(o_re[0][1:0]),
    .col_data(o_cdt[0][63:0]), .col_en(o_ce[0][1:0]), .pe_clear(o_pc[0]),
    .busy(o_bs[0]), .comp_done(o_cd[0]), .error(o_er[0])
  );

  sys_arr_seq #(.ROWS(4), .COLS(3), .DW(32), .KMAX(16), .PE_LAT(6)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .start(start[1]), .k_len(klen[1]),
    .a_vec(avec[1]), .a_valid(av[1]), .a_ready(o_ar[1]),
    .b_vec(bvec[1][95:0]), .b_valid(bv[1]), .b_ready(o_br[1]),
    .pe_err(perr[1]), .row_data(o_rd[1]), .row_en(o_re[1]),
    .col_data(o_cdt[1][95:0]), .col_en(o_ce[1][2:0]), .pe_clear(o_pc[1]),
    .busy(o_bs[1]), .comp_done(o_cd[1]), .error(o_er[1])
  );

  int cyc  = 0;
  int nchk = 0;
  int nerr = 0;

  int R[2]  = '{2, 4};
  int C[2]  = '{2, 3};
  int PL[2] = '{4, 6};

  // Reference model: a run is described by when it was accepted, its K, how
  // many slices have gone in and when the last one went in.
  bit   have_run[2];
  bit   err_m[2];
  int   t_acc[2], kk[2], nx[2], t_last[2], vfrom[2];
  bit   hen[2][NH];
  logic [127:0] ha[2][NH];
  logic [127:0] hb[2][NH];

  function automatic bit m_done(input int d, input int c);
    return have_run[d] && (nx[d] == kk[d]) && (c >= t_last[d] + R[d] + C[d] - 1 + PL[d]);
  endfunction

  function automatic bit m_feed(input int d, input int c);
    return have_run[d] && (c >= t_acc[d] + 2) && (nx[d] < kk[d]);
  endfunction

  function automatic bit m_clear(input int d, input int c);
    return have_run[d] && (c == t_acc[d] + 1);
  endfunction

  function automatic bit m_busy(input int d, input int c);
    return have_run[d] && (c >= t_acc[d] + 1) && !m_done(d, c);
  endfunction

  function automatic logic [127:0] pat(input int r, input logic [7:0] tag);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = {tag, 8'(r), 8'(i), 8'h5A};
    return v;
  endfunction

  task automatic check(input string nm, input int d, input logic [127:0] act,
                       input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d cycle=%0d actual=%0h required=%0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [127:0] act, input logic [127:0] exp);
    check(nm, 0, act, exp);
  endtask

  // Model update: consume the inputs of the cycle that just ended.
  initial begin
    for (int d = 0; d < 2; d++) begin
      have_run[d] = 0; err_m[d] = 0; nx[d] = 0; kk[d] = 0;
      t_acc[d] = 0; t_last[d] = 0; vfrom[d] = 0;
    end
    forever begin
      @(posedge CLK);
      if (cyc >= NH) begin
        $display("FAIL cycle_budget dut0 cycle=%0d actual=%0d required=%0d", cyc, cyc, NH);
        $fatal(1, "cycle budget exceeded");
      end
      for (int d = 0; d < 2; d++) begin
        automatic bit x;
        if (!nRST) begin
          have_run[d] = 0; err_m[d] = 0; nx[d] = 0;
          vfrom[d] = cyc + 1;
          hen[d][cyc] = 0; ha[d][cyc] = '0; hb[d][cyc] = '0;
        end else begin
          x = m_feed(d, cyc) && av[d] && bv[d];
          if ((!have_run[d] || m_done(d, cyc)) && start[d]) begin
            if (klen[d] >= 1 && klen[d] <= 16) begin
              have_run[d] = 1; t_acc[d] = cyc; kk[d] = int'(klen[d]); nx[d] = 0; err_m[d] = 0;
            end else begin
              err_m[d] = 1;
            end
          end else if (m_busy(d, cyc) && perr[d]) begin
            err_m[d] = 1;
          end
          hen[d][cyc] = x;
          ha[d][cyc]  = x ? avec[d] : ((cyc > 0) ? ha[d][cyc-1] : '0);
          hb[d][cyc]  = x ? bvec[d] : ((cyc > 0) ? hb[d][cyc-1] : '0);
          if (x) begin
            nx[d]++;
            t_last[d] = cyc;
          end
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison of every output of both instances.
  initial forever begin
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      automatic logic [127:0] erd = '0, ecd = '0;
      automatic logic [3:0]   ere = '0, ece = '0;
      automatic logic         ear = 0, ebr = 0, epc = 0, ebs = 0, edn = 0, eer = 0;
      automatic int           idx;
      if (nRST) begin
        ear = m_feed(d, cyc) && bv[d];
        ebr = m_feed(d, cyc) && av[d];
        epc = m_clear(d, cyc);
        ebs = m_busy(d, cyc);
        edn = m_done(d, cyc);
        eer = err_m[d];
        for (int i = 0; i < R[d]; i++) begin
          idx = cyc - i - 1;
          if (idx >= 0 && idx >= vfrom[d]) begin
            ere[i] = hen[d][idx];
            erd[i*32 +: 32] = ha[d][idx][i*32 +: 32];
          end
        end
        for (int j = 0; j < C[d]; j++) begin
          idx = cyc - j - 1;
          if (idx >= 0 && idx >= vfrom[d]) begin
            ece[j] = hen[d][idx];
            ecd[j*32 +: 32] = hb[d][idx][j*32 +: 32];
          end
        end
      end
      check("a_ready", d, o_ar[d], ear);
      check("b_ready", d, o_br[d], ebr);
      check("pe_clear", d, o_pc[d], epc);
      check("busy", d, o_bs[d], ebs);
      check("comp_done", d, o_cd[d], edn);
      check("error", d, o_er[d], eer);
      check("row_en", d, o_re[d], ere);
      check("col_en", d, o_ce[d], ece);
      check("row_data", d, o_rd[d], erd);
      check("col_data", d, o_cdt[d], ecd);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    start = '0; av = '0; bv = '0; perr = '0;
  endtask

  // K=2 run on the 2x2 instance, optionally with b_valid dropped in cycle 3.
  task automatic basic(input bit stall);
    int dn;
    logic [127:0] p2, p3;
    dn = stall ? 11 : 10;
    p2 = pat(2, 8'hA1);
    p3 = pat(3, 8'hA1);
    step(); idle_in(); start[0] = 1; klen[0] = 5'd2;
    for (int r = 1; r <= dn + 1; r++) begin
      step();
      start[0] = 0;
      av[0] = (r <= (stall ? 4 : 3));
      bv[0] = av[0] && !(stall && r == 3);
      avec[0] = pat(r, 8'hA1);
      bvec[0] = pat(r, 8'hB1);
      if (!stall && r == 7) begin
        start[0] = 1; klen[0] = 5'd0;
      end
      @(negedge CLK);
      if (r == 1) lit("pe_clear_c1", o_pc[0], 1'b1);
      if (r == dn - 1) lit("done_not_early", o_cd[0], 1'b0);
      if (r == dn) begin
        lit("done_rise", o_cd[0], 1'b1);
        lit("error_clean", o_er[0], 1'b0);
      end
      if (!stall) begin
        if (r == 3) lit("row_en_c3", o_re[0][1:0], 2'b01);
        if (r == 4) begin
          lit("row_en_c4", o_re[0][1:0], 2'b11);
          lit("col_en_c4", o_ce[0][1:0], 2'b11);
          lit("row_data_c4", o_rd[0][63:0], {p2[63:32], p3[31:0]});
        end
        if (r == 5) lit("row_en_c5", o_re[0][1:0], 2'b10);
      end else begin
        if (r == 3) lit("a_ready_stall", o_ar[0], 1'b0);
        if (r == 4) lit("row_en0_bubble", o_re[0][0], 1'b0);
      end
    end
    idle_in();
  endtask

  initial begin
    nRST = 1'b1;
    idle_in();
    klen = '0; avec = '0; bvec = '0;
    #1 nRST = 1'b0;
    repeat (3) step();
    nRST = 1'b1;
    step();

    basic(1'b0);
    basic(1'b1);

    // Rejected starts from DONE, then an accepted one.
    step(); start[0] = 1; klen[0] = 5'd0;
    step(); start[0] = 0;
    @(negedge CLK);
    lit("err_k0", o_er[0], 1'b1);
    lit("busy_k0", o_bs[0], 1'b0);
    lit("clear_k0", o_pc[0], 1'b0);
    lit("done_kept_k0", o_cd[0], 1'b1);
    step(); start[0] = 1; klen[0] = 5'd17;
    step(); start[0] = 0;
    @(negedge CLK);
    lit("err_k17", o_er[0], 1'b1);
    lit("busy_k17", o_bs[0], 1'b0);
    step(); start[0] = 1; klen[0] = 5'd1;
    step(); start[0] = 0;
    @(negedge CLK);
    lit("err_cleared", o_er[0], 1'b0);
    lit("clear_after_ok", o_pc[0], 1'b1);
    for (int r = 2; r <= 10; r++) begin
      step();
      av[0] = (r == 2); bv[0] = (r == 2);
      avec[0] = pat(r, 8'hC1); bvec[0] = pat(r, 8'hD1);
    end
    idle_in();

    // pe_err in FLUSH, sticky into DONE, cleared by the next accepted start.
    step(); start[0] = 1; klen[0] = 5'd1;
    for (int r = 1; r <= 20; r++) begin
      step();
      start[0] = (r == 10);
      av[0] = (r == 2 || r == 12); bv[0] = av[0];
      perr[0] = (r == 5);
      avec[0] = pat(r, 8'hE1); bvec[0] = pat(r, 8'hF1);
      @(negedge CLK);
      if (r == 9) begin
        lit("done_with_err", o_cd[0], 1'b1);
        lit("err_sticky", o_er[0], 1'b1);
      end
      if (r == 10) lit("done_on_restart", o_cd[0], 1'b1);
      if (r == 11) begin
        lit("done_fall", o_cd[0], 1'b0);
        lit("err_drop", o_er[0], 1'b0);
      end
    end
    idle_in();

    // Reset asserted in FLUSH.
    step(); start[0] = 1; klen[0] = 5'd2;
    for (int r = 1; r <= 20; r++) begin
      step();
      start[0] = 0;
      av[0] = (r <= 3); bv[0] = av[0];
      avec[0] = pat(r, 8'h71); bvec[0] = pat(r, 8'h72);
      if (r == 6) nRST = 1'b0;
      if (r == 7) nRST = 1'b1;
      @(negedge CLK);
      if (r == 6) begin
        lit("rst_busy", o_bs[0], 1'b0);
        lit("rst_row_data", o_rd[0], '0);
        lit("rst_col_data", o_cdt[0], '0);
      end
      if (r >= 7 && r % 4 == 0) lit("no_done_after_rst", o_cd[0], 1'b0);
    end
    idle_in();

    // 4x3 instance, K=5, pe_err coincident with the final transfer.
    begin
      logic [127:0] p2;
      p2 = pat(2, 8'h41);
      step(); start[1] = 1; klen[1] = 5'd5;
      for (int r = 1; r <= 20; r++) begin
        step();
        start[1] = 0;
        av[1] = (r <= 6); bv[1] = av[1];
        perr[1] = (r == 6);
        avec[1] = pat(r, 8'h41); bvec[1] = pat(r, 8'h42);
        @(negedge CLK);
        if (r == 2) check("a_ready_c2", 1, o_ar[1], 1'b1);
        if (r == 6) begin
          check("row_en_c6", 1, o_re[1], 4'b1111);
          check("col_en_c6", 1, o_ce[1][2:0], 3'b111);
          check("row3_data_c6", 1, o_rd[1][127:96], p2[127:96]);
        end
        if (r == 17) begin
          check("done_c17", 1, o_cd[1], 1'b0);
          check("busy_c17", 1, o_bs[1], 1'b1);
        end
        if (r == 18) begin
          check("done_c18", 1, o_cd[1], 1'b1);
          check("err_final_xfer", 1, o_er[1], 1'b1);
        end
      end
    end
    idle_in();

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sys_arr_seq.md
Name: sys_arr_seq

Overview:
- Parametrised operand sequencer for an ROWS x COLS output-stationary systolic array of single_float MAC PEs.
- Accepts one K-slice per handshake: one A column vector and one B row vector.
- Skews each lane into the array edge, counts K slices, waits for the wavefront and the PE pipeline to drain, then raises comp_done/error.
- Replaces the fixed 2x2 hard-wired sequencing. Sits between the operand buffers and the PE grid.

Parameters:
ROWS, 2, array rows (A lanes), >=1
COLS, 2, array columns (B lanes), >=1
DW, 32, operand width (single_float)
KMAX, 16, max inner dimension per run
PE_LAT, 4, PE MAC pipeline latency in cycles

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
start  in  1  request a run; sampled in IDLE/DONE only
k_len  in  $clog2(KMAX+1)  inner dimension K, latched on start
a_vec  in  ROWS*DW  A slice; lane i = bits [i*DW +: DW]
a_valid  in  1  a_vec valid
a_ready  out  1  = (state==FEED) & b_valid
b_vec  in  COLS*DW  B slice; lane j
b_valid  in  1  b_vec valid
b_ready  out  1  = (state==FEED) & a_valid
pe_err  in  1  OR of PE FP exceptions
row_data  out  ROWS*DW  skewed A lanes to array west edge
row_en  out  ROWS  per-lane valid
col_data  out  COLS*DW  skewed B lanes to array north edge
col_en  out  COLS  per-lane valid
pe_clear  out  1  clear PE accumulators
busy  out  1  state in {CLEAR, FEED, FLUSH}
comp_done  out  1  high while state==DONE
error  out  1  sticky error flag

Behaviour:
- Reset (async): state=IDLE. All outputs 0, all skew registers and valid bits 0, counters 0.
- Transfer: occurs when a_valid & b_valid & state==FEED. There is no partial transfer; a lone valid on one side waits.
- Skew: lane i of A is delayed i+1 registered cycles from transfer to row_data/row_en. B lane j uses j+1 cycles for col_data/col_en. The skew chain shifts every cycle. A bubble (no transfer) shifts in en=0, and its data is don't-care but held at the last value.
- FSM:
  - IDLE/DONE: on start with 1<=k_len<=KMAX, latch K, clear error, go to CLEAR. On start with k_len==0 or k_len>KMAX, set error, stay, and leave comp_done unchanged.
  - CLEAR: 1 cycle, pe_clear=1, then go to FEED.
  - FEED: increment slice count on each transfer. The transfer that makes count==K moves the FSM to FLUSH next cycle. a_ready/b_ready are 0 outside FEED.
  - FLUSH: lasts exactly ROWS+COLS-2+PE_LAT cycles, tracked by a down-counter, then go to DONE.
  - DONE: comp_done=1 until the next accepted start. An invalid start in DONE keeps DONE.
- Latency: with last transfer in cycle T, comp_done rises in cycle T+ROWS+COLS-1+PE_LAT.
- Error: pe_err sampled high in CLEAR/FEED/FLUSH sets error. error is sticky through DONE and cleared only by an accepted start. start while busy is ignored and does not set error.
- Simultaneous events: pe_err in the same cycle as the final transfer sets error and the FSM still proceeds normally. start while in DONE is accepted, and comp_done falls the next cycle.
- Reset mid-run: everything returns to reset values immediately, and no comp_done is produced.

Test Plan:
- ROWS=COLS=2, PE_LAT=4. start at cycle 0, k_len=2, both valids high from cycle 1.
  - pe_clear in cycle 1; transfers in cycles 2 and 3.
  - row_en[0] in cycles 3–4, row_en[1] in cycles 4–5; col_en likewise.
  - comp_done rises at cycle 10, error=0.
- Same setup, b_valid low in cycle 3 only: 3 FEED cycles, a_ready=0 in cycle 3, a bubble on row_en[0] in cycle 4, comp_done at cycle 11.
- start with k_len=0, then with k_len=17 (KMAX=16): error=1, busy stays 0, no pe_clear. A following valid start clears error.
- pe_err pulsed in a FLUSH cycle: error=1 and stays high with comp_done=1; next valid start drops both.
- Assert nRST low during FLUSH: all outputs 0 asynchronously. After release, state is IDLE and comp_done never rises.
- ROWS=4, COLS=3, PE_LAT=6, k_len=5, no stalls: transfers in cycles 2–6, FLUSH lasts 11 cycles, comp_done at cycle 18. Each lane's data equals the vector element presented i+1 (or j+1) cycles earlier.
